// File: rtl/gpr_wb_pkg.sv
// Shared types for the GPR writeback path: register ids, write sizes and
// the retire-bundle slot/entry layout buffered in the writeback FIFO.
package gpr_wb_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_SLOTS  = 3;

  typedef logic [2:0] gpr_id_t;

  typedef enum logic [1:0] {
    BYTE_LO = 2'd0,
    BYTE_HI = 2'd1,
    WORD    = 2'd2,
    DWORD   = 2'd3
  } gpr_size_e;

  typedef struct packed {
    logic                 we;
    gpr_id_t              dr;
    gpr_size_e            size;
    logic [WB_DATA_W-1:0] data;
  } wb_slot_t;

  typedef struct packed {
    wb_slot_t [WB_SLOTS-1:0] slot;
  } wb_entry_t;

  function automatic logic [7:0] gpr_onehot(input gpr_id_t id, input logic en);
    return en ? (8'd1 << id) : 8'd0;
  endfunction

endpackage

// File: rtl/gpr_wb_fifo.sv
// Circular buffer of retire bundles. Each entry carries a per-slot remain mask
// that the head update port clears as slots are issued.
module gpr_wb_fifo
  import gpr_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                               CLK,
  input  logic                               RST,
  input  logic                               push,
  input  wb_entry_t                          push_entry,
  input  logic                               pop,
  input  logic                               remain_wr,
  input  logic [2:0]                         remain_next,
  output wb_entry_t                          head_entry,
  output logic [2:0]                         head_remain,
  output logic                               full,
  output logic                               empty,
  output logic [$clog2(DEPTH):0]             count,
  output logic [DEPTH-1:0][2:0]              remain_view,
  output gpr_id_t [DEPTH-1:0][2:0]           dr_view
);

  localparam int AW = $clog2(DEPTH);

  wb_entry_t        mem_r    [DEPTH];
  logic [2:0]       remain_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;

  // Entry payload storage; contents are only meaningful where remain is non-zero.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_r[wr_ptr_r] <= push_entry;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  // Pointers, occupancy and remain masks; a popped slot is zeroed so stale entries never reach the pending mask.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        remain_r[i] <= 3'b000;
      end
    end else begin
      if (push) begin
        remain_r[wr_ptr_r] <= {push_entry.slot[2].we, push_entry.slot[1].we, push_entry.slot[0].we};
        wr_ptr_r           <= wr_ptr_r + 1'b1;
      end
      if (pop) begin
        remain_r[rd_ptr_r] <= 3'b000;
        rd_ptr_r           <= rd_ptr_r + 1'b1;
      end else if (remain_wr) begin
        remain_r[rd_ptr_r] <= remain_next;
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Read-side views for the issue logic and the pending-write mask.
  always_comb begin
    head_entry  = mem_r[rd_ptr_r];
    head_remain = remain_r[rd_ptr_r];
    full        = (count_r == (AW+1)'(DEPTH));
    empty       = (count_r == '0);
    count       = count_r;
    for (int i = 0; i < DEPTH; i++) begin
      remain_view[i] = remain_r[i];
      for (int j = 0; j < 3; j++) begin
        dr_view[i][j] = mem_r[i].slot[j].dr;
      end
    end
  end

endmodule

// File: rtl/gpr_writeback.sv
// Drives the three GPR register-file write ports from buffered retire bundles,
// never issuing two writes to the same GPR in one cycle.
module gpr_writeback
  import gpr_wb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = WB_DATA_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_we,
  input  logic [2:0]        in_dr0,
  input  logic [2:0]        in_dr1,
  input  logic [2:0]        in_dr2,
  input  logic [1:0]        in_size0,
  input  logic [1:0]        in_size1,
  input  logic [1:0]        in_size2,
  input  logic [DATA_W-1:0] in_data0,
  input  logic [DATA_W-1:0] in_data1,
  input  logic [DATA_W-1:0] in_data2,
  output logic [2:0]        WRGPR0,
  output logic [2:0]        WRGPR1,
  output logic [2:0]        WRGPR2,
  output logic              WE0,
  output logic              WE1,
  output logic              WE2,
  output logic [1:0]        GPRWE0,
  output logic [1:0]        GPRWE1,
  output logic [1:0]        GPRWE2,
  output logic [DATA_W-1:0] GPR_DIN0,
  output logic [DATA_W-1:0] GPR_DIN1,
  output logic [DATA_W-1:0] GPR_DIN2,
  output logic [7:0]        pending_mask,
  output logic              empty
);

  wb_entry_t                 push_entry_s;
  wb_entry_t                 head_s;
  logic [2:0]                head_remain_s;
  logic [2:0]                issue_s;
  logic [2:0]                remain_next_s;
  logic [7:0]                used_s;
  logic                      push_s;
  logic                      pop_s;
  logic                      fifo_full_s;
  logic                      fifo_empty_s;
  logic [$clog2(DEPTH):0]    fifo_count_s;
  logic [DEPTH-1:0][2:0]     remain_view_s;
  gpr_id_t [DEPTH-1:0][2:0]  dr_view_s;
  logic [7:0]                mask_s;

  logic [2:0]                we_r;
  gpr_id_t                   wrgpr_r [3];
  gpr_size_e                 size_r  [3];
  logic [DATA_W-1:0]         din_r   [3];

  // Pack the incoming bundle; bundles with no enabled slot are dropped at the handshake.
  always_comb begin
    push_entry_s.slot[0] = '{we: in_we[0], dr: in_dr0, size: gpr_size_e'(in_size0), data: in_data0};
    push_entry_s.slot[1] = '{we: in_we[1], dr: in_dr1, size: gpr_size_e'(in_size1), data: in_data1};
    push_entry_s.slot[2] = '{we: in_we[2], dr: in_dr2, size: gpr_size_e'(in_size2), data: in_data2};
    in_ready = !fifo_full_s;
    push_s   = in_valid && !fifo_full_s && (in_we != 3'b000);
  end

  gpr_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK         (CLK),
    .RST         (RST),
    .push        (push_s),
    .push_entry  (push_entry_s),
    .pop         (pop_s),
    .remain_wr   (!fifo_empty_s),
    .remain_next (remain_next_s),
    .head_entry  (head_s),
    .head_remain (head_remain_s),
    .full        (fifo_full_s),
    .empty       (fifo_empty_s),
    .count       (fifo_count_s),
    .remain_view (remain_view_s),
    .dr_view     (dr_view_s)
  );

  // In-order scan of the head entry: a slot issues only if no earlier issued slot claimed its GPR.
  always_comb begin
    issue_s = 3'b000;
    used_s  = 8'h00;
    for (int i = 0; i < 3; i++) begin
      if (!fifo_empty_s && head_remain_s[i] && head_s.slot[i].we && !used_s[head_s.slot[i].dr]) begin
        issue_s[i] = 1'b1;
        used_s     = used_s | gpr_onehot(head_s.slot[i].dr, 1'b1);
      end else begin
        issue_s[i] = 1'b0;
      end
    end
    remain_next_s = head_remain_s & ~issue_s;
    pop_s         = !fifo_empty_s && (remain_next_s == 3'b000);
  end

  // Write-port registers; idle ports keep id, size and data stable.
  always_ff @(posedge CLK) begin
    if (RST) begin
      we_r <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        wrgpr_r[i] <= 3'd0;
        size_r[i]  <= BYTE_LO;
        din_r[i]   <= '0;
      end
    end else begin
      we_r <= issue_s;
      for (int i = 0; i < 3; i++) begin
        if (issue_s[i]) begin
          wrgpr_r[i] <= head_s.slot[i].dr;
          size_r[i]  <= head_s.slot[i].size;
          din_r[i]   <= head_s.slot[i].data;
        end else begin
          wrgpr_r[i] <= wrgpr_r[i];
          size_r[i]  <= size_r[i];
          din_r[i]   <= din_r[i];
        end
      end
    end
  end

  // Outstanding destinations: buffered un-issued slots plus strobes currently on the ports.
  always_comb begin
    mask_s = 8'h00;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < 3; j++) begin
        mask_s = mask_s | gpr_onehot(dr_view_s[i][j], remain_view_s[i][j]);
      end
    end
    for (int j = 0; j < 3; j++) begin
      mask_s = mask_s | gpr_onehot(wrgpr_r[j], we_r[j]);
    end
  end

  assign pending_mask = mask_s;
  assign empty        = (fifo_count_s == '0) && (we_r == 3'b000);

  assign WE0      = we_r[0];
  assign WE1      = we_r[1];
  assign WE2      = we_r[2];
  assign WRGPR0   = wrgpr_r[0];
  assign WRGPR1   = wrgpr_r[1];
  assign WRGPR2   = wrgpr_r[2];
  assign GPRWE0   = size_r[0];
  assign GPRWE1   = size_r[1];
  assign GPRWE2   = size_r[2];
  assign GPR_DIN0 = din_r[0];
  assign GPR_DIN1 = din_r[1];
  assign GPR_DIN2 = din_r[2];

endmodule

// File: tb/tb_gpr_writeback.sv
// Scoreboard bench for gpr_writeback: expected write cycles are queued at
// acceptance and a negedge monitor compares every cycle of port activity.
module tb_gpr_writeback;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_we = 3'b000;
  logic [2:0]  in_dr0 = 3'd0, in_dr1 = 3'd0, in_dr2 = 3'd0;
  logic [1:0]  in_size0 = 2'd0, in_size1 = 2'd0, in_size2 = 2'd0;
  logic [31:0] in_data0 = 32'd0, in_data1 = 32'd0, in_data2 = 32'd0;
  logic [2:0]  WRGPR0, WRGPR1, WRGPR2;
  logic        WE0, WE1, WE2;
  logic [1:0]  GPRWE0, GPRWE1, GPRWE2;
  logic [31:0] GPR_DIN0, GPR_DIN1, GPR_DIN2;
  logic [7:0]  pending_mask;
  logic        empty;

  gpr_writeback #(.DEPTH(4), .DATA_W(32)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready), .in_we(in_we),
    .in_dr0(in_dr0), .in_dr1(in_dr1), .in_dr2(in_dr2),
    .in_size0(in_size0), .in_size1(in_size1), .in_size2(in_size2),
    .in_data0(in_data0), .in_data1(in_data1), .in_data2(in_data2),
    .WRGPR0(WRGPR0), .WRGPR1(WRGPR1), .WRGPR2(WRGPR2),
    .WE0(WE0), .WE1(WE1), .WE2(WE2),
    .GPRWE0(GPRWE0), .GPRWE1(GPRWE1), .GPRWE2(GPRWE2),
    .GPR_DIN0(GPR_DIN0), .GPR_DIN1(GPR_DIN1), .GPR_DIN2(GPR_DIN2),
    .pending_mask(pending_mask), .empty(empty)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [2:0]       mask;
    logic [2:0][2:0]  dr;
    logic [2:0][1:0]  sz;
    logic [2:0][31:0] d;
  } grp_t;

  grp_t             exp_q[$];
  int               n_cmp = 0;
  int               n_bad = 0;
  int               stall_cnt = 0;
  logic             mon_en = 1'b0;
  logic [2:0][2:0]  last_dr = '0;
  logic [2:0][1:0]  last_sz = '0;
  logic [2:0][31:0] last_d  = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // A slot's issue cycle is its rank among earlier enabled slots with the same GPR.
  task automatic push_expect(input logic [2:0] we, input logic [2:0][2:0] dr,
                             input logic [2:0][1:0] sz, input logic [2:0][31:0] d);
    int   rank[3];
    int   ng = 0;
    grp_t g;
    for (int i = 0; i < 3; i++) begin
      rank[i] = 0;
      if (we[i]) begin
        for (int j = 0; j < i; j++) if (we[j] && dr[j] == dr[i]) rank[i]++;
        if (rank[i] + 1 > ng) ng = rank[i] + 1;
      end
    end
    for (int k = 0; k < ng; k++) begin
      g = '0;
      for (int i = 0; i < 3; i++) begin
        if (we[i] && rank[i] == k) begin
          g.mask[i] = 1'b1;
          g.dr[i] = dr[i];
          g.sz[i] = sz[i];
          g.d[i]  = d[i];
        end
      end
      exp_q.push_back(g);
    end
  endtask

  // Called right after a negedge; returns right after the negedge following acceptance.
  task automatic send(input logic [2:0] we, input logic [2:0][2:0] dr,
                      input logic [2:0][1:0] sz, input logic [2:0][31:0] d);
    logic rdy;
    int   waited = 0;
    in_valid = 1'b1; in_we = we;
    in_dr0 = dr[0]; in_dr1 = dr[1]; in_dr2 = dr[2];
    in_size0 = sz[0]; in_size1 = sz[1]; in_size2 = sz[2];
    in_data0 = d[0]; in_data1 = d[1]; in_data2 = d[2];
    forever begin
      rdy = in_ready;
      @(posedge CLK);
      if (rdy === 1'b1) break;
      stall_cnt++;
      waited++;
      if (waited > 200) begin
        n_cmp++; n_bad++;
        $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", waited);
        break;
      end
      @(negedge CLK);
    end
    if (rdy === 1'b1) push_expect(we, dr, sz, d);
    @(negedge CLK);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int c = 0;
    while ((exp_q.size() != 0 || empty !== 1'b1) && c < 300) begin
      @(negedge CLK);
      c++;
    end
    chk("drain_empty", {63'd0, empty}, 64'd1);
    chk("drain_queue", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: pops one expected group per strobe cycle, checks idle-port hold and the pending mask.
  initial begin
    logic [2:0]       we_v;
    logic [2:0][2:0]  a_dr;
    logic [2:0][1:0]  a_sz;
    logic [2:0][31:0] a_d;
    logic [7:0]       m;
    grp_t             g;
    forever begin
      @(negedge CLK);
      if (mon_en) begin
        we_v = {WE2, WE1, WE0};
        a_dr = {WRGPR2, WRGPR1, WRGPR0};
        a_sz = {GPRWE2, GPRWE1, GPRWE0};
        a_d  = {GPR_DIN2, GPR_DIN1, GPR_DIN0};
        if (we_v != 3'b000) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_we", {61'd0, we_v}, 64'd0);
          end else begin
            g = exp_q.pop_front();
            chk("we_mask", {61'd0, we_v}, {61'd0, g.mask});
            for (int i = 0; i < 3; i++) begin
              if (g.mask[i]) begin
                chk("wrgpr", {61'd0, a_dr[i]}, {61'd0, g.dr[i]});
                chk("gprwe", {62'd0, a_sz[i]}, {62'd0, g.sz[i]});
                chk("gpr_din", {32'd0, a_d[i]}, {32'd0, g.d[i]});
              end
            end
          end
        end
        for (int i = 0; i < 3; i++) begin
          if (!we_v[i]) begin
            chk("hold_dr", {61'd0, a_dr[i]}, {61'd0, last_dr[i]});
            chk("hold_sz", {62'd0, a_sz[i]}, {62'd0, last_sz[i]});
            chk("hold_din", {32'd0, a_d[i]}, {32'd0, last_d[i]});
          end else begin
            last_dr[i] = a_dr[i];
            last_sz[i] = a_sz[i];
            last_d[i]  = a_d[i];
          end
        end
        m = 8'h00;
        for (int q = 0; q < exp_q.size(); q++)
          for (int i = 0; i < 3; i++)
            if (exp_q[q].mask[i]) m[exp_q[q].dr[i]] = 1'b1;
        for (int i = 0; i < 3; i++) if (we_v[i]) m[a_dr[i]] = 1'b1;
        chk("pending_mask", {56'd0, pending_mask}, {56'd0, m});
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0][2:0]  dr;
    logic [2:0][1:0]  sz;
    logic [2:0][31:0] d;
    int               s0;

    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_empty", {63'd0, empty}, 64'd1);
    chk("rst_mask", {56'd0, pending_mask}, 64'd0);
    chk("rst_we", {61'd0, WE2, WE1, WE0}, 64'd0);
    chk("rst_din0", {32'd0, GPR_DIN0}, 64'd0);
    chk("rst_gprwe", {58'd0, GPRWE2, GPRWE1, GPRWE0}, 64'd0);
    mon_en = 1'b1;

    // Single dword write to EAX: strobe exactly two cycles after acceptance.
    dr = '0; sz = {2'd0, 2'd0, 2'd3}; d = {32'd0, 32'd0, 32'h12345678};
    send(3'b001, dr, sz, d);
    chk("t1_we_early", {63'd0, WE0}, 64'd0);
    chk("t1_mask_k1", {56'd0, pending_mask}, 64'h01);
    chk("t1_not_empty", {63'd0, empty}, 64'd0);
    @(negedge CLK);
    chk("t1_we0", {63'd0, WE0}, 64'd1);
    chk("t1_wrgpr0", {61'd0, WRGPR0}, 64'd0);
    chk("t1_gprwe0", {62'd0, GPRWE0}, 64'd3);
    chk("t1_din0", {32'd0, GPR_DIN0}, 64'h12345678);
    chk("t1_mask_k2", {56'd0, pending_mask}, 64'h01);
    @(negedge CLK);
    chk("t1_we0_off", {63'd0, WE0}, 64'd0);
    chk("t1_mask_clr", {56'd0, pending_mask}, 64'h00);
    chk("t1_empty", {63'd0, empty}, 64'd1);
    repeat (3) @(negedge CLK);
    chk("t1_hold_din0", {32'd0, GPR_DIN0}, 64'h12345678);

    // AL, AH, ECX: slots 0 and 2 together, slot 1 alone next cycle.
    dr = {3'd1, 3'd0, 3'd0}; sz = {2'd3, 2'd1, 2'd0}; d = {32'h5, 32'hBB, 32'hAA};
    send(3'b111, dr, sz, d);
    chk("t2_c0", {61'd0, WE2, WE1, WE0}, 64'b000);
    @(negedge CLK);
    chk("t2_c1", {61'd0, WE2, WE1, WE0}, 64'b101);
    @(negedge CLK);
    chk("t2_c2", {61'd0, WE2, WE1, WE0}, 64'b010);
    @(negedge CLK);
    chk("t2_c3", {61'd0, WE2, WE1, WE0}, 64'b000);

    // Three writes to EDX serialize over three cycles in slot order.
    dr = {3'd2, 3'd2, 3'd2}; sz = {2'd3, 2'd2, 2'd0}; d = {32'h33, 32'h22, 32'h11};
    send(3'b111, dr, sz, d);
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      chk("t3_we", {61'd0, WE2, WE1, WE0}, 64'(3'b001 << c));
      chk("t3_ready", {63'd0, in_ready}, 64'd1);
    end
    drain();

    // Conflict-free bundles sustain one per cycle.
    s0 = stall_cnt;
    for (int j = 0; j < 5; j++) begin
      dr = {3'(j + 2), 3'(j + 1), 3'(j)};
      sz = {2'(j), 2'(j + 1), 2'(j + 2)};
      d  = {$urandom(), $urandom(), $urandom()};
      send(3'b111, dr, sz, d);
    end
    chk("t4_no_stall", 64'(stall_cnt - s0), 64'd0);
    drain();

    // Serialized bundles back up the FIFO until in_ready drops.
    s0 = stall_cnt;
    for (int j = 0; j < 8; j++) begin
      dr = {3{3'(j)}};
      sz = {2'd3, 2'd2, 2'd1};
      d  = {$urandom(), $urandom(), $urandom()};
      send(3'b111, dr, sz, d);
    end
    chk("t4_stalled", {63'd0, (stall_cnt > s0)}, 64'd1);
    drain();

    // Reset with a bundle buffered: nothing from it may appear.
    dr = {3'd0, 3'd0, 3'd5}; sz = {2'd0, 2'd0, 2'd2}; d = {32'd0, 32'd0, 32'hDEAD};
    send(3'b001, dr, sz, d);
    chk("t5_mask_pre", {56'd0, pending_mask}, 64'h20);
    RST = 1'b1;
    @(posedge CLK);
    exp_q.delete();
    last_dr = '0; last_sz = '0; last_d = '0;
    @(negedge CLK);
    RST = 1'b0;
    chk("t5_we", {61'd0, WE2, WE1, WE0}, 64'd0);
    chk("t5_mask", {56'd0, pending_mask}, 64'd0);
    chk("t5_empty", {63'd0, empty}, 64'd1);
    chk("t5_ready", {63'd0, in_ready}, 64'd1);
    chk("t5_wrgpr", {55'd0, WRGPR2, WRGPR1, WRGPR0}, 64'd0);
    repeat (5) @(negedge CLK);

    // Randomized traffic with a narrow GPR range to force conflicts.
    for (int n = 0; n < 300; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge CLK);
      dr = {3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3))};
      sz = {2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      d  = {$urandom(), $urandom(), $urandom()};
      send(3'($urandom_range(0, 7)), dr, sz, d);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
